// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external combinational ALU between two requesters.
// Round-robin grant, valid/ready request handshake, a single op in flight, and
// operands held on the ALU for MUL_CYCLES cycles when the op is a multiply.
module alu_share_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o,
    output logic        rsp_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_MUL = 3'b100;

    // Counter only needs to hold MUL_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             id_q, id_d;
    logic [31:0]      result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             grant_any;
    logic             grant_id;
    logic             accept;

    // Round-robin grant: a lone valid port wins; on contention the port that
    // was not served last wins. Ready is only offered while idle.
    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid_i;
        end
        req0_ready_o = (state_q == ST_IDLE) && grant_any && !grant_id;
        req1_ready_o = (state_q == ST_IDLE) && grant_any && grant_id;
        accept       = (state_q == ST_IDLE) && grant_any;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = grant_id ? req1_op_i : req0_op_i;
                    a_d          = grant_id ? req1_a_i  : req0_a_i;
                    b_d          = grant_id ? req1_b_i  : req0_b_i;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = (op_d == OP_MUL) ? MUL_LOAD : '0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d = alu_data_i;
                    zero_d   = (alu_data_i == 32'd0);
                    err_d    = (op_q > OP_MUL);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight op and favours port 0 next.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // The ALU always sees the latched op, so its inputs never glitch mid-op.
    always_comb begin
        alu_data1_o = a_q;
        alu_data2_o = b_q;
        alu_ctrl_o  = op_q;
        rsp_valid_o = (state_q == ST_RESP);
        rsp_id_o    = id_q;
        rsp_data_o  = result_q;
        rsp_zero_o  = zero_q;
        rsp_err_o   = err_q;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the shared ALU.
module tb_alu_share_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o;
    logic [2:0]  req0_op_i;
    logic [31:0] req0_a_i, req0_b_i;
    logic        req1_valid_i, req1_ready_o;
    logic [2:0]  req1_op_i;
    logic [31:0] req1_a_i, req1_b_i;
    logic [31:0] alu_data1_o, alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_err_o;
    logic [31:0] rsp_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_share_ctrl #(.MUL_CYCLES(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op_i(req0_op_i), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op_i(req1_op_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o)
    );

    // Shared ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, others yield 0.
    always_comb begin
        case (alu_ctrl_o)
            3'b000:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b001:  alu_data_i = alu_data1_o - alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b011:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b100:  alu_data_i = alu_data1_o * alu_data2_o;
            default: alu_data_i = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #2;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    logic [31:0] held_data;

    initial begin
        rst_i = 1'b0;
        req0_valid_i = 0; req0_op_i = 0; req0_a_i = 0; req0_b_i = 0;
        req1_valid_i = 0; req1_op_i = 0; req1_a_i = 0; req1_b_i = 0;
        rsp_ready_i = 0;
        #12;
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_data", rsp_data_o, 0);
        chk("rst_alu1", alu_data1_o, 0);
        chk("rst_ready0", req0_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // 1: lone ADD on port 0
        tick();
        req0_valid_i = 1; req0_op_i = 3'b000; req0_a_i = 5; req0_b_i = 7;
        #1;
        chk("t1_ready0", req0_ready_o, 1);
        chk("t1_ready1", req1_ready_o, 0);
        tick();                                   // accept edge
        req0_valid_i = 0;
        chk("t1_nvalid", rsp_valid_o, 0);
        chk("t1_alu1", alu_data1_o, 5);
        tick();
        chk("t1_valid", rsp_valid_o, 1);
        chk("t1_data", rsp_data_o, 12);
        chk("t1_id", rsp_id_o, 0);
        chk("t1_zero", rsp_zero_o, 0);
        rsp_ready_i = 1;
        tick();
        chk("t1_done", rsp_valid_o, 0);
        rsp_ready_i = 0;

        // 2: contention after reset, grants alternate 0,1,0,1
        do_reset();
        req0_valid_i = 1; req0_op_i = 3'b001; req0_a_i = 9; req0_b_i = 9;
        req1_valid_i = 1; req1_op_i = 3'b011; req1_a_i = 1; req1_b_i = 2;
        rsp_ready_i = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_ready0", req0_ready_o, (k % 2 == 0) ? 1 : 0);
            chk("t2_ready1", req1_ready_o, (k % 2 == 1) ? 1 : 0);
            tick();                               // accept
            chk("t2_busy", req0_ready_o | req1_ready_o, 0);
            tick();                               // response
            chk("t2_valid", rsp_valid_o, 1);
            chk("t2_id", rsp_id_o, k % 2);
            chk("t2_data", rsp_data_o, (k % 2 == 0) ? 0 : 3);
            chk("t2_zero", rsp_zero_o, (k % 2 == 0) ? 1 : 0);
            chk("t2_bubble", req0_ready_o | req1_ready_o, 0);
            tick();                               // back to idle
        end
        req0_valid_i = 0; req1_valid_i = 0; rsp_ready_i = 0;

        // 3: MUL held for 3 cycles
        req0_valid_i = 1; req0_op_i = 3'b100; req0_a_i = 32'h0001_0000; req0_b_i = 32'h10;
        tick();                                   // accept edge N
        req0_valid_i = 0; req0_a_i = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            chk("t3_nvalid", rsp_valid_o, 0);
            chk("t3_alu1", alu_data1_o, 32'h0001_0000);
            chk("t3_alu2", alu_data2_o, 32'h10);
            chk("t3_ctrl", alu_ctrl_o, 3'b100);
            tick();
        end
        chk("t3_valid", rsp_valid_o, 1);
        chk("t3_data", rsp_data_o, 32'h0010_0000);

        // 4: response back-pressure
        req0_valid_i = 1; req0_op_i = 3'b000; req0_a_i = 1; req0_b_i = 1;
        req1_valid_i = 1; req1_op_i = 3'b010; req1_a_i = 6; req1_b_i = 3;
        held_data = rsp_data_o;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_valid", rsp_valid_o, 1);
            chk("t4_data", rsp_data_o, 32'h0010_0000);
            chk("t4_id", rsp_id_o, 0);
            chk("t4_ready", req0_ready_o | req1_ready_o, 0);
        end
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        chk("t4_idle", rsp_valid_o, 0);
        chk("t4_ready1", req1_ready_o, 1);
        chk("t4_ready0", req0_ready_o, 0);
        req0_valid_i = 0; req1_valid_i = 0;

        // 5: invalid op code
        req0_valid_i = 1; req0_op_i = 3'b111; req0_a_i = 3; req0_b_i = 4;
        #1;
        chk("t5_ready0", req0_ready_o, 1);
        tick();
        req0_valid_i = 0;
        tick();
        chk("t5_valid", rsp_valid_o, 1);
        chk("t5_data", rsp_data_o, 0);
        chk("t5_zero", rsp_zero_o, 1);
        chk("t5_err", rsp_err_o, 1);
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;

        // 6: reset during MUL execution
        req0_valid_i = 1; req0_op_i = 3'b100; req0_a_i = 2; req0_b_i = 3;
        tick();
        req0_valid_i = 0;
        tick();
        rst_i = 1'b0;
        #1;
        chk("t6_rstvalid", rsp_valid_o, 0);
        chk("t6_rstalu", alu_data1_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t6_nvalid", rsp_valid_o, 0);
        end
        req0_valid_i = 1; req0_op_i = 3'b010; req0_a_i = 32'hF0; req0_b_i = 32'h3C;
        req1_valid_i = 1; req1_op_i = 3'b011; req1_a_i = 1;      req1_b_i = 1;
        #1;
        chk("t6_ready0", req0_ready_o, 1);
        chk("t6_ready1", req1_ready_o, 0);
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        chk("t6_ctrl", alu_ctrl_o, 3'b010);
        tick();
        chk("t6_data", rsp_data_o, 32'h30);
        chk("t6_id", rsp_id_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
